fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Fetch-stage PC sequencer feeding the branch predictor and the instruction memory.
//  Drives f_pc to the predictor and consumes f_predict_addr/f_predict_valid to pick the next PC.
//  Issues one instruction-memory request at a time and hands fetched instructions to DECODE.
//  Applies EXEC redirects on mispredict and kills any wrong-path instruction in flight.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset
//  PC_STEP    4              sequential PC increment, in bytes
// PORTS
//  clk              in   1   clock, all state updates on rising edge
//  rst              in   1   synchronous reset, active-high
//  f_pc             out  32  PC of the current fetch; also the predictor lookup address
//  f_predict_addr   in   32  predicted target for the f_pc presented on the previous cycle
//  f_predict_valid  in   1   f_predict_addr is usable
//  x_redirect       in   1   EXEC: branch resolved against prediction, restart fetch
//  x_redirect_addr  in   32  EXEC: correct next PC
//  imem_req_valid   out  1   memory request valid
//  imem_req_addr    out  32  request address, always equal to f_pc
//  imem_req_ready   in   1   memory accepts request this cycle
//  imem_resp_valid  in   1   response data valid, exactly one per accepted request
//  imem_resp_data   in   32  fetched instruction word
//  d_stall          in   1   DECODE cannot accept an instruction this cycle
//  d_valid          out  1   d_instr/d_pc hold a valid instruction for DECODE
//  d_instr          out  32  instruction word to DECODE
//  d_pc             out  32  PC of d_instr; DECODE returns it to the predictor
// BEHAVIOUR
//  Reset: f_pc=RESET_PC, imem_req_valid=0, d_valid=0, d_instr=0, d_pc=0, kill=0, state=BOOT.
//  FSM states: BOOT, REQ, WAIT, HOLD.
//   BOOT: one cycle after reset -> REQ. Lets the registered predictor see f_pc before use.
//   REQ : imem_req_valid=1. imem_req_valid && imem_req_ready -> WAIT.
//   WAIT: wait for imem_resp_valid; the predictor output is sampled on that cycle.
//         If the slot is free, the response is written to the output and the FSM goes to REQ.
//         If the output slot is full and held by d_stall, the FSM goes to HOLD.
//   HOLD: the response word is kept internally until the slot drains, then -> REQ.
//  Next PC, computed when the response is accepted: kill ? redirect_pc :
//   f_predict_valid ? f_predict_addr : f_pc+PC_STEP. Addition is 32-bit modulo, wrap 32'hFFFF_FFFC->0.
//  Predictor latency: f_pc is stable >=1 cycle before sampling, which covers the 1-cycle registered lookup.
//  Output slot: d_valid set on write; cleared when !d_stall and nothing new is written.
//   While d_stall=1, d_valid/d_instr/d_pc hold steady.
//  Redirect (x_redirect=1), with highest priority, in any state except BOOT:
//   - d_valid cleared the same edge (wrong-path instruction dropped even if d_stall).
//   - REQ/HOLD: f_pc <= x_redirect_addr, any HOLD word discarded, -> REQ.
//   - WAIT: redirect_pc <= x_redirect_addr, kill <= 1. The pending response is discarded (not
//     written to the output), then f_pc <= redirect_pc, kill <= 0, -> REQ.
//   - A redirect during BOOT only loads f_pc.
//  Simultaneous redirect and response in WAIT: the response is discarded and the FSM goes to REQ at x_redirect_addr.
//  imem_req_addr is stable while imem_req_valid=1 && !imem_req_ready, except under a redirect.
//  The memory must tolerate a withdrawn request, and a redirect mid-REQ may change the address.
//  At most one request is outstanding. Stray imem_resp_valid outside WAIT is ignored.
//  Reset mid-operation: all state returns to reset values. Any response that arrives later is ignored.
// CONFIGURATION
//  FETCH_BUF_EN defined: a 2-entry FIFO replaces the single output slot and HOLD.
//   Fetch continues while the FIFO has space. REQ is entered only if the FIFO is not full, counting
//   entries plus the outstanding request. The FIFO head drives d_*. A redirect flushes the whole FIFO.
//  FETCH_BUF_EN undefined: single output slot plus HOLD as above. Throughput is at best 1 instruction per 2 cycles.
// TESTING
//  Reset, 1-cycle mem, no prediction -> imem_req_addr 0,4,8,C; d_pc follows the same sequence.
//  Predictor hits for f_pc=0x8 with target 0x40 -> next request 0x40; d_pc sequence 0x8, 0x40.
//  x_redirect=1 with addr 0x100 while in WAIT on 0xC -> response for 0xC never reaches d_valid.
//   Next request is 0x100.
//  d_stall held 5 cycles with d_valid=1 -> d_instr/d_pc constant. No new request without
//   FETCH_BUF_EN; exactly 2 buffered with it.
//  imem_req_ready low 3 cycles -> imem_req_addr constant. Exactly one response accepted per grant.
//  f_pc=0xFFFF_FFFC, no prediction -> next imem_req_addr 0x0000_0000.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC sequencer: BOOT/REQ/WAIT/HOLD FSM, one outstanding imem request, EXEC redirect/kill.
// Define FETCH_BUF_EN to replace the single output slot and HOLD with a 2-entry output FIFO.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] f_pc,
   input  logic [31:0] f_predict_addr,
   input  logic        f_predict_valid,
   input  logic        x_redirect,
   input  logic [31:0] x_redirect_addr,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        d_stall,
   output logic        d_valid,
   output logic [31:0] d_instr,
   output logic [31:0] d_pc
);

   typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

   state_t      state;
   logic        kill;
   logic [31:0] redirect_pc;
   logic [31:0] next_pc;

   assign imem_req_addr = f_pc;

   always_comb begin
      next_pc = f_predict_valid ? f_predict_addr : (f_pc + 32'(PC_STEP));
   end

`ifdef FETCH_BUF_EN

   logic [31:0] buf_instr [2];
   logic [31:0] buf_pc    [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic        pop;
   logic [1:0]  cnt_pop;

   assign d_valid = (count != 2'd0);
   assign d_instr = buf_instr[rd_ptr];
   assign d_pc    = buf_pc[rd_ptr];
   assign pop     = d_valid && !d_stall;
   assign cnt_pop = count - 2'(pop);

   // HOLD here means "FIFO full, waiting for DECODE to free an entry before requesting".
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= BOOT;
         f_pc           <= RESET_PC;
         imem_req_valid <= 1'b0;
         kill           <= 1'b0;
         redirect_pc    <= '0;
         rd_ptr         <= 1'b0;
         wr_ptr         <= 1'b0;
         count          <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            buf_instr[i] <= '0;
            buf_pc[i]    <= '0;
         end
      end else begin
         if (pop) rd_ptr <= ~rd_ptr;
         count <= cnt_pop;
         if (x_redirect && state != BOOT) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
         end
         case (state)
            BOOT: begin
               if (x_redirect) f_pc <= x_redirect_addr;
               state          <= REQ;
               imem_req_valid <= 1'b1;
            end
            REQ: begin
               if (x_redirect) begin
                  f_pc <= x_redirect_addr;
               end else if (imem_req_ready) begin
                  state          <= WAIT;
                  imem_req_valid <= 1'b0;
               end
            end
            WAIT: begin
               if (x_redirect) begin
                  if (imem_resp_valid) begin
                     f_pc           <= x_redirect_addr;
                     kill           <= 1'b0;
                     state          <= REQ;
                     imem_req_valid <= 1'b1;
                  end else begin
                     redirect_pc <= x_redirect_addr;
                     kill        <= 1'b1;
                  end
               end else if (imem_resp_valid) begin
                  kill <= 1'b0;
                  if (kill) begin
                     f_pc           <= redirect_pc;
                     state          <= REQ;
                     imem_req_valid <= 1'b1;
                  end else begin
                     f_pc              <= next_pc;
                     buf_instr[wr_ptr] <= imem_resp_data;
                     buf_pc[wr_ptr]    <= f_pc;
                     wr_ptr            <= ~wr_ptr;
                     count             <= cnt_pop + 2'd1;
                     if (cnt_pop == 2'd0) begin
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                     end else begin
                        state <= HOLD;
                     end
                  end
               end
            end
            HOLD: begin
               if (x_redirect) begin
                  f_pc           <= x_redirect_addr;
                  state          <= REQ;
                  imem_req_valid <= 1'b1;
               end else if (cnt_pop != 2'd2) begin
                  state          <= REQ;
                  imem_req_valid <= 1'b1;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

`else

   logic [31:0] hold_instr;
   logic [31:0] hold_pc;
   logic        slot_free;

   assign slot_free = !d_valid || !d_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= BOOT;
         f_pc           <= RESET_PC;
         imem_req_valid <= 1'b0;
         kill           <= 1'b0;
         redirect_pc    <= '0;
         d_valid        <= 1'b0;
         d_instr        <= '0;
         d_pc           <= '0;
         hold_instr     <= '0;
         hold_pc        <= '0;
      end else begin
         if (!d_stall) d_valid <= 1'b0;
         if (x_redirect && state != BOOT) d_valid <= 1'b0;
         case (state)
            BOOT: begin
               if (x_redirect) f_pc <= x_redirect_addr;
               state          <= REQ;
               imem_req_valid <= 1'b1;
            end
            REQ: begin
               if (x_redirect) begin
                  f_pc <= x_redirect_addr;
               end else if (imem_req_ready) begin
                  state          <= WAIT;
                  imem_req_valid <= 1'b0;
               end
            end
            WAIT: begin
               if (x_redirect) begin
                  if (imem_resp_valid) begin
                     f_pc           <= x_redirect_addr;
                     kill           <= 1'b0;
                     state          <= REQ;
                     imem_req_valid <= 1'b1;
                  end else begin
                     redirect_pc <= x_redirect_addr;
                     kill        <= 1'b1;
                  end
               end else if (imem_resp_valid) begin
                  kill <= 1'b0;
                  if (kill) begin
                     f_pc           <= redirect_pc;
                     state          <= REQ;
                     imem_req_valid <= 1'b1;
                  end else begin
                     f_pc <= next_pc;
                     if (slot_free) begin
                        d_valid        <= 1'b1;
                        d_instr        <= imem_resp_data;
                        d_pc           <= f_pc;
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                     end else begin
                        hold_instr <= imem_resp_data;
                        hold_pc    <= f_pc;
                        state      <= HOLD;
                     end
                  end
               end
            end
            HOLD: begin
               if (x_redirect) begin
                  f_pc           <= x_redirect_addr;
                  state          <= REQ;
                  imem_req_valid <= 1'b1;
               end else if (!d_stall) begin
                  d_valid        <= 1'b1;
                  d_instr        <= hold_instr;
                  d_pc           <= hold_pc;
                  state          <= REQ;
                  imem_req_valid <= 1'b1;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit (default build): 1-cycle memory model,
// registered predictor model, redirect/stall/backpressure/wrap scenarios.
module tb_fetch_pc_unit;

   logic        clk;
   logic        rst;
   logic [31:0] f_pc;
   logic [31:0] f_predict_addr;
   logic        f_predict_valid;
   logic        x_redirect;
   logic [31:0] x_redirect_addr;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        d_stall;
   logic        d_valid;
   logic [31:0] d_instr;
   logic [31:0] d_pc;

   int          checks   = 0;
   int          failures = 0;

   logic        mem_hold;
   logic        pend;
   logic [31:0] pend_addr;
   logic        pred_en;
   int          nresp;
   logic [31:0] rq [$];
   logic [31:0] dq [$];
   logic [31:0] iq [$];

   fetch_pc_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .f_pc            (f_pc),
      .f_predict_addr  (f_predict_addr),
      .f_predict_valid (f_predict_valid),
      .x_redirect      (x_redirect),
      .x_redirect_addr (x_redirect_addr),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .d_stall         (d_stall),
      .d_valid         (d_valid),
      .d_instr         (d_instr),
      .d_pc            (d_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: log what crossed each interface on this edge, then drive memory and predictor.
   task automatic cyc();
      logic        g;
      logic [31:0] a;
      logic [31:0] p;
      logic        dv;
      logic [31:0] dp;
      logic [31:0] di;
      g  = imem_req_valid && imem_req_ready;
      a  = imem_req_addr;
      p  = f_pc;
      dv = d_valid && !d_stall && !rst;
      dp = d_pc;
      di = d_instr;
      @(posedge clk);
      #1;
      if (dv) begin
         dq.push_back(dp);
         iq.push_back(di);
      end
      if (g) begin
         rq.push_back(a);
         pend      = 1'b1;
         pend_addr = a;
      end
      if (pend && !mem_hold) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(pend_addr);
         pend            = 1'b0;
         nresp++;
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'hDEAD_BEEF;
      end
      f_predict_valid = pred_en && (p == 32'h0000_0008);
      f_predict_addr  = f_predict_valid ? 32'h0000_0040 : 32'h0BAD_0000;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      x_redirect     = 1'b0;
      d_stall        = 1'b0;
      imem_req_ready = 1'b1;
      mem_hold       = 1'b0;
      pred_en        = 1'b0;
      cyc();
      cyc();
      pend            = 1'b0;
      imem_resp_valid = 1'b0;
      nresp           = 0;
      rq.delete();
      dq.delete();
      iq.delete();
      chk("rst_f_pc", f_pc, 32'h0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_d_valid", 32'(d_valid), 32'h0);
      chk("rst_d_instr", d_instr, 32'h0);
      chk("rst_d_pc", d_pc, 32'h0);
      rst = 1'b0;
   endtask

   initial begin
      int n_c;
      logic [31:0] held_pc;
      logic [31:0] held_instr;
      rst             = 1'b1;
      x_redirect      = 1'b0;
      x_redirect_addr = 32'h0;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      d_stall         = 1'b0;
      f_predict_valid = 1'b0;
      f_predict_addr  = 32'h0;
      mem_hold        = 1'b0;
      pend            = 1'b0;
      pend_addr       = 32'h0;
      pred_en         = 1'b0;
      nresp           = 0;

      // Sequential fetch, no prediction
      do_reset();
      run(12);
      chk("seq_req_count", 32'(rq.size() >= 4), 32'h1);
      chk("seq_req0", rq[0], 32'h0);
      chk("seq_req1", rq[1], 32'h4);
      chk("seq_req2", rq[2], 32'h8);
      chk("seq_req3", rq[3], 32'hC);
      chk("seq_dpc0", dq[0], 32'h0);
      chk("seq_dpc1", dq[1], 32'h4);
      chk("seq_dpc2", dq[2], 32'h8);
      chk("seq_dpc3", dq[3], 32'hC);
      chk("seq_dinstr2", iq[2], mem_word(32'h8));

      // Predictor hit at 0x8 -> 0x40
      do_reset();
      pred_en = 1'b1;
      run(12);
      chk("pred_req2", rq[2], 32'h8);
      chk("pred_req3", rq[3], 32'h40);
      chk("pred_req4", rq[4], 32'h44);
      chk("pred_dpc2", dq[2], 32'h8);
      chk("pred_dpc3", dq[3], 32'h40);
      chk("pred_dinstr3", iq[3], mem_word(32'h40));

      // Redirect while waiting on 0xC; its late response must be dropped
      do_reset();
      for (int i = 0; i < 40 && rq.size() < 4; i++) begin
         if (rq.size() == 3) mem_hold = 1'b1;
         cyc();
      end
      chk("kill_wait_reached", 32'(rq.size()), 32'd4);
      chk("kill_wait_addr", rq[3], 32'hC);
      x_redirect      = 1'b1;
      x_redirect_addr = 32'h100;
      cyc();
      x_redirect = 1'b0;
      mem_hold   = 1'b0;
      run(8);
      chk("kill_next_req", rq[4], 32'h100);
      chk("kill_dpc3", dq[3], 32'h100);
      chk("kill_dinstr3", iq[3], mem_word(32'h100));
      n_c = 0;
      foreach (dq[k]) if (dq[k] == 32'hC) n_c++;
      chk("kill_no_C", 32'(n_c), 32'd0);

      // DECODE stall for 5 cycles with a valid instruction
      do_reset();
      for (int i = 0; i < 20 && !d_valid; i++) cyc();
      chk("stall_dvalid_start", 32'(d_valid), 32'h1);
      held_pc    = 32'h0;
      held_instr = mem_word(32'h0);
      d_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("stall_dvalid", 32'(d_valid), 32'h1);
         chk("stall_dpc", d_pc, held_pc);
         chk("stall_dinstr", d_instr, held_instr);
      end
      chk("stall_no_req", 32'(imem_req_valid), 32'h0);
      chk("stall_req_count", 32'(rq.size()), 32'd2);
      d_stall = 1'b0;
      run(8);
      chk("stall_dpc0", dq[0], 32'h0);
      chk("stall_dpc1", dq[1], 32'h4);
      chk("stall_dpc2", dq[2], 32'h8);

      // Memory backpressure: ready low 3 cycles
      do_reset();
      imem_req_ready = 1'b0;
      cyc();
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("bp_req_valid", 32'(imem_req_valid), 32'h1);
         chk("bp_req_addr", imem_req_addr, 32'h0);
      end
      imem_req_ready = 1'b1;
      run(8);
      imem_req_ready = 1'b0;
      run(4);
      chk("bp_grants", 32'(rq.size()), 32'd4);
      chk("bp_resps", 32'(nresp), 32'd4);
      chk("bp_delivered", 32'(dq.size()), 32'd4);
      chk("bp_dpc3", dq[3], 32'hC);
      chk("bp_hold_addr", imem_req_addr, 32'h10);

      // Redirect during BOOT to 0xFFFF_FFFC, then wrap to 0
      do_reset();
      x_redirect      = 1'b1;
      x_redirect_addr = 32'hFFFF_FFFC;
      cyc();
      x_redirect = 1'b0;
      chk("wrap_boot_fpc", f_pc, 32'hFFFF_FFFC);
      run(8);
      chk("wrap_req0", rq[0], 32'hFFFF_FFFC);
      chk("wrap_req1", rq[1], 32'h0);
      chk("wrap_dpc0", dq[0], 32'hFFFF_FFFC);
      chk("wrap_dpc1", dq[1], 32'h0);

      // Redirect coincident with the response in WAIT
      do_reset();
      cyc();
      cyc();
      chk("coinc_granted", 32'(rq.size()), 32'd1);
      x_redirect      = 1'b1;
      x_redirect_addr = 32'h200;
      cyc();
      x_redirect = 1'b0;
      chk("coinc_fpc", f_pc, 32'h200);
      run(6);
      chk("coinc_req1", rq[1], 32'h200);
      chk("coinc_dpc0", dq[0], 32'h200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
